// File: rtl/cell_unscaler_if.sv
// Cell-request / pixel-stream bundle for cell_unscaler.
//   Request side : req_valid, req_ready, cell_column, cell_row
//   Pixel side   : pix_valid, pix_ready, pixel_column, pixel_row,
//                  pix_last, pix_border, done
//   master modport: the requester / frame-buffer writer side
//   slave  modport: the cell_unscaler side
interface cell_unscaler_if #(
  parameter int unsigned CELL_BITS = 7,
  parameter int unsigned PIX_BITS  = 12
);

  logic                 req_valid;
  logic                 req_ready;
  logic [CELL_BITS-1:0] cell_column;
  logic [CELL_BITS-1:0] cell_row;

  logic                 pix_valid;
  logic                 pix_ready;
  logic [PIX_BITS-1:0]  pixel_column;
  logic [PIX_BITS-1:0]  pixel_row;
  logic                 pix_last;
  logic                 pix_border;
  logic                 done;

  modport master (
    output req_valid, cell_column, cell_row, pix_ready,
    input  req_ready, pix_valid, pixel_column, pixel_row,
           pix_last, pix_border, done
  );

  modport slave (
    input  req_valid, cell_column, cell_row, pix_ready,
    output req_ready, pix_valid, pixel_column, pixel_row,
           pix_last, pix_border, done
  );

endinterface

// File: rtl/cell_unscaler.sv
// cell_unscaler: expands one world-map cell coordinate into every screen
// pixel covered by that cell, emitted in raster order (column fastest).
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-high reset
//   bus    - cell_unscaler_if.slave
//            request : req_valid/req_ready handshake, cell_column, cell_row
//            pixels  : pix_valid/pix_ready handshake, pixel_column, pixel_row,
//                      pix_last (final pixel of the cell),
//                      pix_border (pixel on the cell perimeter),
//                      done (one-cycle pulse after the last transfer)
//
// Optional feature: define CELL_UNSCALER_BORDER_EN to generate pix_border;
// otherwise pix_border is tied low.
module cell_unscaler #(
  parameter int unsigned COL_SCALE = 8,   // power of 2
  parameter int unsigned ROW_SCALE = 6,
  parameter int unsigned CELL_BITS = 7,
  parameter int unsigned PIX_BITS  = 12
) (
  input logic            clk,
  input logic            reset,
  cell_unscaler_if.slave bus
);

  localparam int unsigned COL_SHIFT = $clog2(COL_SCALE);
  localparam int unsigned SC_BITS   = (COL_SCALE > 1) ? $clog2(COL_SCALE) : 1;
  localparam int unsigned SR_BITS   = (ROW_SCALE > 1) ? $clog2(ROW_SCALE) : 1;
  localparam logic [SC_BITS-1:0] SC_MAX = SC_BITS'(COL_SCALE - 1);
  localparam logic [SR_BITS-1:0] SR_MAX = SR_BITS'(ROW_SCALE - 1);

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } state_t;

  // Multiplier-free row base: sum of shifted copies for each set bit of
  // ROW_SCALE, e.g. (r<<2)+(r<<1) for 6.
  function automatic logic [PIX_BITS-1:0] row_base(input logic [CELL_BITS-1:0] r);
    logic [PIX_BITS-1:0] acc;
    logic [PIX_BITS-1:0] rx;
    acc = '0;
    rx  = PIX_BITS'(r);
    for (int i = 0; i < PIX_BITS; i++) begin
      if (ROW_SCALE[i]) acc = acc + (rx << i);
    end
    return acc;
  endfunction

  state_t              state_q,    state_d;
  logic [PIX_BITS-1:0] base_col_q, base_col_d;
  logic [PIX_BITS-1:0] base_row_q, base_row_d;
  logic [SC_BITS-1:0]  sub_col_q,  sub_col_d;
  logic [SR_BITS-1:0]  sub_row_q,  sub_row_d;

  logic                req_ready_q,    req_ready_d;
  logic                pix_valid_q,    pix_valid_d;
  logic [PIX_BITS-1:0] pixel_column_q, pixel_column_d;
  logic [PIX_BITS-1:0] pixel_row_q,    pixel_row_d;
  logic                pix_last_q,     pix_last_d;
  logic                done_q,         done_d;
  logic                walk_d;

  // Next-state, counter advance and registered-output preparation.
  always_comb begin
    state_d    = state_q;
    base_col_d = base_col_q;
    base_row_d = base_row_q;
    sub_col_d  = sub_col_q;
    sub_row_d  = sub_row_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          base_col_d = PIX_BITS'(bus.cell_column) << COL_SHIFT;
          base_row_d = row_base(bus.cell_row);
          sub_col_d  = '0;
          sub_row_d  = '0;
          state_d    = WALK;
        end
      end
      default: begin
        if (pix_valid_q && bus.pix_ready) begin
          if (sub_col_q == SC_MAX) begin
            sub_col_d = '0;
            if (sub_row_q == SR_MAX) begin
              sub_row_d = '0;
              state_d   = IDLE;
              done_d    = 1'b1;
            end else begin
              sub_row_d = sub_row_q + SR_BITS'(1);
            end
          end else begin
            sub_col_d = sub_col_q + SC_BITS'(1);
          end
        end
      end
    endcase

    // Outputs are derived from the next state so they register alongside it;
    // a stalled transfer leaves every input unchanged, so outputs hold.
    walk_d         = (state_d == WALK);
    req_ready_d    = !walk_d;
    pix_valid_d    = walk_d;
    pixel_column_d = walk_d ? (base_col_d + PIX_BITS'(sub_col_d)) : '0;
    pixel_row_d    = walk_d ? (base_row_d + PIX_BITS'(sub_row_d)) : '0;
    pix_last_d     = walk_d && (sub_col_d == SC_MAX) && (sub_row_d == SR_MAX);
  end

  // State, counters and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      base_col_q     <= '0;
      base_row_q     <= '0;
      sub_col_q      <= '0;
      sub_row_q      <= '0;
      req_ready_q    <= 1'b1;
      pix_valid_q    <= 1'b0;
      pixel_column_q <= '0;
      pixel_row_q    <= '0;
      pix_last_q     <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_col_q     <= base_col_d;
      base_row_q     <= base_row_d;
      sub_col_q      <= sub_col_d;
      sub_row_q      <= sub_row_d;
      req_ready_q    <= req_ready_d;
      pix_valid_q    <= pix_valid_d;
      pixel_column_q <= pixel_column_d;
      pixel_row_q    <= pixel_row_d;
      pix_last_q     <= pix_last_d;
      done_q         <= done_d;
    end
  end

`ifdef CELL_UNSCALER_BORDER_EN
  logic pix_border_q, pix_border_d;

  // Perimeter flag, aligned with the pixel it describes.
  always_comb begin
    pix_border_d = walk_d && ((sub_col_d == '0) || (sub_col_d == SC_MAX) ||
                              (sub_row_d == '0) || (sub_row_d == SR_MAX));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pix_border_q <= 1'b0;
    else       pix_border_q <= pix_border_d;
  end

  assign bus.pix_border = pix_border_q;
`else
  assign bus.pix_border = 1'b0;
`endif

  assign bus.req_ready    = req_ready_q;
  assign bus.pix_valid    = pix_valid_q;
  assign bus.pixel_column = pixel_column_q;
  assign bus.pixel_row    = pixel_row_q;
  assign bus.pix_last     = pix_last_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_cell_unscaler.sv
// Self-checking bench for cell_unscaler: a stimulus process issues cell
// requests and pushes the expected pixel stream into a scoreboard; an
// independent monitor pops and compares every accepted pixel.
module tb_cell_unscaler;

  localparam int COLS = 8;
  localparam int ROWS = 6;
`ifdef CELL_UNSCALER_BORDER_EN
  localparam bit BORDER_ON = 1'b1;
`else
  localparam bit BORDER_ON = 1'b0;
`endif

  logic clk;
  logic reset;

  cell_unscaler_if #(.CELL_BITS(7), .PIX_BITS(12)) bus ();

  cell_unscaler #(
    .COL_SCALE(8), .ROW_SCALE(6), .CELL_BITS(7), .PIX_BITS(12)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int col;
    int row;
    bit last;
    bit border;
    int cx;
    int cy;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int xfer_count   = 0;
  int border_count = 0;
  int ready_mode   = 0;
  int last_wait    = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the cell covers an 8x6 pixel block starting at
  // (cx*8, cy*6), walked row by row.
  task automatic push_cell(input int cx, input int cy);
    exp_t e;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        e.col    = cx * COLS + c;
        e.row    = cy * ROWS + r;
        e.last   = (r == ROWS - 1) && (c == COLS - 1);
        e.border = BORDER_ON && (c == 0 || c == COLS - 1 || r == 0 || r == ROWS - 1);
        e.cx     = cx;
        e.cy     = cy;
        sb.push_back(e);
      end
    end
  endtask

  // Downstream ready pattern: 0 = always, 1 = 1,0,0,1 repeating, 2 = random.
  initial begin
    int phase;
    phase = 0;
    bus.pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.pix_ready = 1'b1;
        1: begin
          case (phase % 4)
            0: bus.pix_ready = 1'b1;
            1: bus.pix_ready = 1'b0;
            2: bus.pix_ready = 1'b0;
            default: bus.pix_ready = 1'b1;
          endcase
        end
        default: bus.pix_ready = ($urandom_range(0, 3) != 0);
      endcase
      phase++;
    end
  end

  // Monitor: scoreboard pops, stall stability, done pulse placement.
  initial begin
    exp_t e;
    bit   done_due;
    bit   done_next;
    bit   stall_prev;
    int   s_col, s_row, s_last, s_border;
    done_due   = 1'b0;
    stall_prev = 1'b0;
    s_col = 0; s_row = 0; s_last = 0; s_border = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        done_due   = 1'b0;
        stall_prev = 1'b0;
        continue;
      end
      done_next = 1'b0;
      check("done_pulse", int'(bus.done), int'(done_due));
      if (done_due) begin
        check("ready_after_last", int'(bus.req_ready), 1);
        check("valid_after_last", int'(bus.pix_valid), 0);
      end
      if (bus.pix_valid) check("ready_low_in_walk", int'(bus.req_ready), 0);
      if (stall_prev) begin
        check("stall_valid",  int'(bus.pix_valid), 1);
        check("stall_col",    int'(bus.pixel_column), s_col);
        check("stall_row",    int'(bus.pixel_row), s_row);
        check("stall_last",   int'(bus.pix_last), s_last);
        check("stall_border", int'(bus.pix_border), s_border);
      end
      if (bus.pix_valid && bus.pix_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pixel: got (%0d,%0d) expected none",
                   bus.pixel_column, bus.pixel_row);
        end else begin
          e = sb.pop_front();
          check("pix_col",    int'(bus.pixel_column), e.col);
          check("pix_row",    int'(bus.pixel_row), e.row);
          check("pix_last",   int'(bus.pix_last), int'(e.last));
          check("pix_border", int'(bus.pix_border), int'(e.border));
          check("roundtrip_cx", int'(bus.pixel_column) / COLS, e.cx);
          check("roundtrip_cy", int'(bus.pixel_row) / ROWS, e.cy);
          done_next = e.last;
        end
        xfer_count++;
        if (bus.pix_border) border_count++;
      end
      stall_prev = bus.pix_valid && !bus.pix_ready;
      s_col    = int'(bus.pixel_column);
      s_row    = int'(bus.pixel_row);
      s_last   = int'(bus.pix_last);
      s_border = int'(bus.pix_border);
      done_due = done_next;
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, int'(bus.req_ready), 1);
    check({tag, "_pix_valid"}, int'(bus.pix_valid), 0);
    check({tag, "_pix_col"},   int'(bus.pixel_column), 0);
    check({tag, "_pix_row"},   int'(bus.pixel_row), 0);
    check({tag, "_pix_last"},  int'(bus.pix_last), 0);
    check({tag, "_border"},    int'(bus.pix_border), 0);
    check({tag, "_done"},      int'(bus.done), 0);
  endtask

  // Present a request until accepted; optionally keep req_valid high after.
  task automatic send(input int cx, input int cy, input bit hold);
    int waits;
    bus.req_valid   = 1'b1;
    bus.cell_column = 7'(cx);
    bus.cell_row    = 7'(cy);
    waits = 0;
    while (!bus.req_ready && waits < 1000) begin
      @(negedge clk);
      waits++;
    end
    last_wait = waits;
    if (!bus.req_ready) begin
      total++;
      bad++;
      $display("FAIL req_accept_timeout: got waits=%0d expected acceptance", waits);
      bus.req_valid = 1'b0;
    end else begin
      @(posedge clk);
      push_cell(cx, cy);
      #1;
      if (!hold) bus.req_valid = 1'b0;
    end
  endtask

  task automatic wait_done(output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.done) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done after %0d cycles expected pulse", cyc);
    end
  endtask

  initial begin
    int cyc;
    int start;
    reset           = 1'b1;
    bus.req_valid   = 1'b0;
    bus.cell_column = '0;
    bus.cell_row    = '0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // 1: cell (0,0), full-rate ready
    ready_mode = 0;
    send(0, 0, 1'b0);
    wait_done(cyc);
    check("t1_cycles_to_done", cyc, 49);

    // 2: far corner, no 12-bit overflow
    send(127, 127, 1'b0);
    wait_done(cyc);
    check("t2_cycles_to_done", cyc, 49);

    // 3: stalls with 1,0,0,1 ready pattern
    ready_mode = 1;
    start = xfer_count;
    send(5, 10, 1'b0);
    wait_done(cyc);
    check("t3_transfers", xfer_count - start, 48);

    // 4: req_valid held across a walk; second request waits for it to end
    ready_mode = 0;
    send(2, 3, 1'b1);
    send(4, 4, 1'b0);
    check("t4_accept_wait", last_wait, 49);
    wait_done(cyc);

    // 5: reset mid-walk after 20 transfers
    start = xfer_count;
    send(10, 10, 1'b0);
    for (int i = 0; i < 200 && (xfer_count - start) < 20; i++) begin
      @(posedge clk);
      #1;
    end
    check("t5_transfers_before_reset", xfer_count - start, 20);
    #1 reset = 1'b1;
    #1;
    check("t5_async_valid", int'(bus.pix_valid), 0);
    check("t5_async_done",  int'(bus.done), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check_reset_state("t5_post");
    send(1, 1, 1'b0);
    wait_done(cyc);

    // 6: border flags on cell (0,0)
    start = border_count;
    send(0, 0, 1'b0);
    wait_done(cyc);
    check("t6_border_pixels", border_count - start, BORDER_ON ? 24 : 0);

    // Random cells under random backpressure
    ready_mode = 2;
    for (int n = 0; n < 8; n++) begin
      start = xfer_count;
      send(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)), 1'b0);
      wait_done(cyc);
      check("rand_transfers", xfer_count - start, 48);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
